skewed_mem_control: RTL and testbench

Parametrised successor to the master memory controller. On a start request it streams a num_row × num_col tile out of the unified buffer. Each cycle it produces one read address and one read enable per array column. An optional diagonal skew mode staggers column c by c cycles so the data arrives as the wavefront the systolic array expects. It adds an address stride, a stall input, a busy flag and a one-cycle done pulse. It sits between the master control FSM and the per-column memory banks.

---
 rtl/skewed_mem_control.sv | 108 ++++++++++
 tb/tb_skewed_mem_control.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/skewed_mem_control.sv
// Streams a num_row x num_col tile out of the unified buffer as per-column read
// addresses/enables, optionally skewed diagonally for the systolic array wavefront.
module skewed_mem_control #(
    parameter int addr_width   = 8,
    parameter int width_height = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [addr_width-1:0]                base_addr,
    input  logic [addr_width-1:0]                stride,
    input  logic [$clog2(width_height)-1:0]      num_row,
    input  logic [$clog2(width_height)-1:0]      num_col,
    input  logic                                 skew,
    input  logic                                 pause,
    output logic [addr_width*width_height-1:0]   out_addr,
    output logic [width_height-1:0]             out_en,
    output logic                                 busy,
    output logic                                 done
);

    localparam int cnt_w = $clog2(width_height);
    localparam int t_w   = $clog2(2 * width_height);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [t_w-1:0]          t;
    logic [addr_width-1:0]   base_q;
    logic [addr_width-1:0]   stride_q;
    logic [cnt_w-1:0]        num_row_q;
    logic [cnt_w-1:0]        num_col_q;
    logic                    skew_q;

    logic [t_w:0]                          row [width_height];
    logic [width_height-1:0]              beat_en;
    logic [addr_width*width_height-1:0]   beat_addr;
    logic [t_w-1:0]                        last_t;

    // row[c] carries one extra sign bit so columns not yet reached by the wavefront go negative.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        beat_en   = '0;
        beat_addr = '0;
        for (int c = 0; c < width_height; c++) begin
            row[c] = {1'b0, t} - (skew_q ? (t_w+1)'(c) : '0);
            if ((cnt_w'(c) <= num_col_q) && !row[c][t_w] &&
                (row[c][t_w-1:0] <= t_w'(num_row_q))) begin
                beat_en[c] = 1'b1;
                beat_addr[c*addr_width +: addr_width] =
                    base_q + addr_width'(row[c][t_w-1:0]) * stride_q;
            end
        end
        last_t = t_w'(num_row_q) + (skew_q ? t_w'(num_col_q) : '0);
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            t         <= '0;
            base_q    <= '0;
            stride_q  <= '0;
            num_row_q <= '0;
            num_col_q <= '0;
            skew_q    <= 1'b0;
            out_en    <= '0;
            out_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            out_en   <= '0;
            out_addr <= '0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        base_q    <= base_addr;
                        stride_q  <= stride;
                        num_row_q <= num_row;
                        num_col_q <= num_col;
                        skew_q    <= skew;
                        t         <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        out_en   <= beat_en;
                        out_addr <= beat_addr;
                        t        <= t + 1'b1;
                        if (t == last_t) state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_skewed_mem_control.sv
// Self-checking bench for skewed_mem_control (4x4 array, 8-bit addresses) against
// a per-beat arithmetic model of which columns read which tile row.
module tb_skewed_mem_control;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  base_addr;
    logic [7:0]  stride;
    logic [1:0]  num_row;
    logic [1:0]  num_col;
    logic        skew;
    logic        pause;
    logic [31:0] out_addr;
    logic [3:0]  out_en;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    skewed_mem_control #(.addr_width(8), .width_height(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .stride    (stride),
        .num_row   (num_row),
        .num_col   (num_col),
        .skew      (skew),
        .pause     (pause),
        .out_addr  (out_addr),
        .out_en    (out_en),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat k of a tile: column c reads tile row k - c*skew when that row exists.
    function automatic void beat_model(input int k, input int base, input int strd,
                                       input int nr, input int nc, input int sk,
                                       output logic [3:0] en, output logic [31:0] addr);
        en   = '0;
        addr = '0;
        for (int c = 0; c < 4; c++) begin
            int r;
            r = k - (sk != 0 ? c : 0);
            if (c <= nc && r >= 0 && r <= nr) begin
                en[c] = 1'b1;
                addr[c*8 +: 8] = 8'((base + r * strd) % 256);
            end
        end
    endfunction

    // Inputs other than pause are irrelevant once a transfer is latched.
    task automatic scramble();
        start     = 1'($urandom);
        base_addr = 8'($urandom);
        stride    = 8'($urandom);
        num_row   = 2'($urandom);
        num_col   = 2'($urandom);
        skew      = 1'($urandom);
    endtask

    task automatic run_transfer(input int base, input int strd, input int nr, input int nc,
                                input int sk, input logic [31:0] pmask, input int stop_after);
        int          t_last;
        int          k;
        int          j;
        bit          paused;
        logic [3:0]  e_en;
        logic [31:0] e_addr;
        t_last = nr + (sk != 0 ? nc : 0);

        @(negedge clk);
        start     = 1'b1;
        base_addr = 8'(base);
        stride    = 8'(strd);
        num_row   = 2'(nr);
        num_col   = 2'(nc);
        skew      = 1'(sk);
        pause     = 1'b0;
        @(posedge clk); #1;
        check("accept_en",   32'(out_en), 32'h0);
        check("accept_addr", out_addr,    32'h0);
        check("accept_busy", 32'(busy),   32'h1);
        check("accept_done", 32'(done),   32'h0);

        k = 0;
        j = 0;
        while (k <= t_last) begin
            @(negedge clk);
            scramble();
            paused = (j < 32) ? pmask[j] : 1'b0;
            pause  = paused;
            @(posedge clk); #1;
            if (paused) begin
                e_en   = '0;
                e_addr = '0;
            end else begin
                beat_model(k, base, strd, nr, nc, sk, e_en, e_addr);
            end
            check(paused ? "pause_en" : "beat_en",     32'(out_en), 32'(e_en));
            check(paused ? "pause_addr" : "beat_addr", out_addr,    e_addr);
            check("beat_busy", 32'(busy), 32'h1);
            check("beat_done", 32'(done), 32'h0);
            if (!paused) begin
                if (k == stop_after) return;
                k++;
            end
            j++;
        end

        @(negedge clk);
        scramble();
        pause = 1'($urandom);
        @(posedge clk); #1;
        check("done_pulse", 32'(done),   32'h1);
        check("done_busy",  32'(busy),   32'h0);
        check("done_en",    32'(out_en), 32'h0);
        check("done_addr",  out_addr,    32'h0);

        @(negedge clk);
        start = 1'b0;
        pause = 1'b0;
        @(posedge clk); #1;
        check("idle_done", 32'(done),   32'h0);
        check("idle_busy", 32'(busy),   32'h0);
        check("idle_en",   32'(out_en), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        stride    = '0;
        num_row   = '0;
        num_col   = '0;
        skew      = 1'b0;
        pause     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en",   32'(out_en), 32'h0);
        check("rst_addr", out_addr,    32'h0);
        check("rst_busy", 32'(busy),   32'h0);
        check("rst_done", 32'(done),   32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_transfer(8'h10, 1, 2, 1, 0, 32'h0, -1);          // lockstep
        run_transfer(0,     4, 1, 3, 1, 32'h0, -1);          // diagonal skew
        run_transfer(8'h10, 1, 2, 1, 0, 32'b110, -1);        // two-cycle stall after beat 0
        run_transfer(8'hFE, 1, 3, 0, 0, 32'h0, -1);          // address wrap
        run_transfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 3, 3, 1, 32'h0, -1);

        // Reset mid-transfer with a start on the same edge, then replay.
        run_transfer(8'h10, 1, 2, 1, 0, 32'h0, 2);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check("midrst_en",   32'(out_en), 32'h0);
        check("midrst_addr", out_addr,    32'h0);
        check("midrst_busy", 32'(busy),   32'h0);
        check("midrst_done", 32'(done),   32'h0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        @(posedge clk); #1;
        check("postrst_busy", 32'(busy),   32'h0);
        check("postrst_en",   32'(out_en), 32'h0);
        run_transfer(8'h10, 1, 2, 1, 0, 32'h0, -1);

        for (int n = 0; n < 25; n++) begin
            run_transfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 1)),
                         32'($urandom_range(0, 255)) & 32'($urandom_range(0, 255)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
